// File: rtl/ex_muldiv.sv
// Execute-stage RISC-V M-extension unit: 2-cycle multiplier and 32-iteration
// restoring divider behind a small FSM that stalls decode until write-back.
module ex_muldiv #(
  parameter int XLEN      = 32,
  parameter int DIV_ITERS = XLEN,
  parameter int RADDR_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         funct3_i,
  input  logic [XLEN-1:0]    op1_i,
  input  logic [XLEN-1:0]    op2_i,
  input  logic [RADDR_W-1:0] reg_waddr_i,
  input  logic               flush_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [XLEN-1:0]    result_o,
  output logic               reg_we_o,
  output logic [RADDR_W-1:0] reg_waddr_o
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [5:0]      LAST_ITER = 6'(DIV_ITERS - 1);
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic c);
    return c ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
    return neg_if(v, sgn & v[XLEN-1]);
  endfunction

  state_t state, state_n;

  logic [1:0]      funct3_p0;
  logic [XLEN-1:0] op1_p0, op2_p0, rem_p0, quo_p0;
  logic [5:0]      cnt_p0;
  logic            neg_q_p0, neg_r_p0;

  logic            accept, is_div, div_zero, div_ovf, special, signed_div, last_iter;
  logic [XLEN-1:0] special_res, mul_res, div_res, rem_n, quo_n;
  logic [XLEN:0]   shifted, diff;
  logic signed [2*XLEN-1:0] mul_a, mul_b, prod;

  assign accept     = (state == IDLE) & start_i & ~flush_i & ~rst;
  assign is_div     = funct3_i[2];
  assign signed_div = ~funct3_i[0];
  assign div_zero   = (op2_i == '0);
  assign div_ovf    = signed_div & (op1_i == MIN_NEG) & (&op2_i);
  assign special    = is_div & (div_zero | div_ovf);
  assign last_iter  = (cnt_p0 == LAST_ITER);

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = funct3_i[1] ? op1_i : '1;
    else          special_res = funct3_i[1] ? '0 : MIN_NEG;
  end

  // Multiply: low 64 bits of the sign-extended product are exact for all four ops
  always_comb begin
    mul_a = $signed({{XLEN{(funct3_p0 == 2'b01 || funct3_p0 == 2'b10) && op1_p0[XLEN-1]}}, op1_p0});
    mul_b = $signed({{XLEN{(funct3_p0 == 2'b01) && op2_p0[XLEN-1]}}, op2_p0});
    prod  = mul_a * mul_b;
    mul_res = (funct3_p0 == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Divide: one restoring step per cycle; remainder < divisor keeps the trial in XLEN+1 bits
  always_comb begin
    shifted = {rem_p0, quo_p0[XLEN-1]};
    diff    = shifted - {1'b0, op2_p0};
    rem_n   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quo_n   = {quo_p0[XLEN-2:0], ~diff[XLEN]};
    div_res = funct3_p0[1] ? neg_if(rem_n, neg_r_p0) : neg_if(quo_n, neg_q_p0);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = !is_div ? MUL : (special ? DONE : DIV);
      MUL:  state_n = DONE;
      DIV:  if (last_iter) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush_i) state_n = IDLE;
  end

  assign busy_o   = (state == MUL) | (state == DIV) | accept;
  assign done_o   = (state == DONE);
  assign reg_we_o = done_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt_p0      <= '0;
      result_o    <= '0;
      reg_waddr_o <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt_p0      <= '0;
        reg_waddr_o <= reg_waddr_i;
        if (special) result_o <= special_res;
      end else if (state == DIV) begin
        cnt_p0 <= cnt_p0 + 6'd1;
      end
      if (!flush_i && state == MUL)              result_o <= mul_res;
      if (!flush_i && state == DIV && last_iter) result_o <= div_res;
    end
  end

  // Operand capture and divider datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      funct3_p0 <= funct3_i[1:0];
      op1_p0    <= op1_i;
      op2_p0    <= is_div ? magnitude(op2_i, signed_div) : op2_i;
      rem_p0    <= '0;
      quo_p0    <= magnitude(op1_i, signed_div);
      neg_q_p0  <= signed_div & (op1_i[XLEN-1] ^ op2_i[XLEN-1]);
      neg_r_p0  <= signed_div & op1_i[XLEN-1];
    end else if (state == DIV) begin
      rem_p0 <= rem_n;
      quo_p0 <= quo_n;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed vector bench for ex_muldiv: latency, stall, result and write-back
// address per op, plus flush and mid-operation reset sequences.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op1_i, op2_i;
  logic [4:0]  reg_waddr_i;
  logic        flush_i;
  logic        busy_o, done_o, reg_we_o;
  logic [31:0] result_o;
  logic [4:0]  reg_waddr_o;

  int n_checks = 0;
  int n_fail   = 0;

  ex_muldiv #(.XLEN(32), .DIV_ITERS(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .funct3_i(funct3_i),
    .op1_i(op1_i), .op2_i(op2_i), .reg_waddr_i(reg_waddr_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  lat;
    bit  busy_ok;
    @(negedge clk);
    start_i = 1'b1; funct3_i = v.f3; op1_i = v.a; op2_i = v.b; reg_waddr_i = v.rd;
    #1 chk({v.name, " busy_accept"}, 32'(busy_o), 32'd1);
    @(negedge clk);
    start_i = 1'b0; op1_i = '0; op2_i = '0; reg_waddr_i = '0;
    lat = 1; busy_ok = 1'b1;
    while (!done_o && lat < 40) begin
      if (!busy_o) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
    chk({v.name, " result"}, result_o, v.exp);
    chk({v.name, " waddr"}, 32'(reg_waddr_o), 32'(v.rd));
    chk({v.name, " we_done"}, {30'd0, reg_we_o, done_o}, 32'd3);
    chk({v.name, " busy_done"}, 32'(busy_o), 32'd0);
    chk({v.name, " busy_inflight"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    chk({v.name, " done_pulse"}, 32'(done_o), 32'd0);
    chk({v.name, " result_hold"}, result_o, v.exp);
  endtask

  initial begin
    vecs[0]  = '{"MUL_7x-3",      3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 2};
    vecs[1]  = '{"MULHU_ones",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 2};
    vecs[2]  = '{"MULH_ones",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 2};
    vecs[3]  = '{"MULHSU_ones",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 2};
    vecs[4]  = '{"MULH_minmin",   3'b001, 32'h80000000, 32'h80000000, 5'd9,  32'h40000000, 2};
    vecs[5]  = '{"DIV_-7/2",      3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 33};
    vecs[6]  = '{"REM_-7/2",      3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 33};
    vecs[7]  = '{"DIVU_100/7",    3'b101, 32'd100,      32'd7,        5'd12, 32'd14,       33};
    vecs[8]  = '{"REMU_100/7",    3'b111, 32'd100,      32'd7,        5'd13, 32'd2,        33};
    vecs[9]  = '{"DIV_7/-3",      3'b100, 32'd7,        32'hFFFFFFFD, 5'd14, 32'hFFFFFFFE, 33};
    vecs[10] = '{"REM_7/-3",      3'b110, 32'd7,        32'hFFFFFFFD, 5'd15, 32'd1,        33};
    vecs[11] = '{"DIVU_5/0",      3'b101, 32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 1};
    vecs[12] = '{"REMU_5/0",      3'b111, 32'd5,        32'd0,        5'd17, 32'd5,        1};
    vecs[13] = '{"DIV_ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1};
    vecs[14] = '{"REM_ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0,        1};
    vecs[15] = '{"DIV_-5/0",      3'b100, 32'hFFFFFFFB, 32'd0,        5'd20, 32'hFFFFFFFF, 1};

    rst = 1'b1; start_i = 1'b0; funct3_i = '0; op1_i = '0; op2_i = '0;
    reg_waddr_i = '0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy",   32'(busy_o), 32'd0);
    chk("reset_done",   32'(done_o), 32'd0);
    chk("reset_we",     32'(reg_we_o), 32'd0);
    chk("reset_result", result_o, 32'd0);
    chk("reset_waddr",  32'(reg_waddr_o), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Flush at T+10 of a divide, then a multiply accepted at T+11
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b101; op1_i = 32'd1000; op2_i = 32'd3; reg_waddr_i = 5'd21;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    #1 chk("flush_busy_t10", 32'(busy_o), 32'd1);
    @(negedge clk);
    flush_i = 1'b0;
    #1 chk("flush_idle_busy", 32'(busy_o), 32'd0);
    chk("flush_no_done", 32'(done_o), 32'd0);
    start_i = 1'b1; funct3_i = 3'b000; op1_i = 32'd3; op2_i = 32'd4; reg_waddr_i = 5'd22;
    #1 chk("flush_new_accept", 32'(busy_o), 32'd1);
    @(negedge clk);
    start_i = 1'b0;
    chk("flush_mul_t12_done", 32'(done_o), 32'd0);
    @(negedge clk);
    chk("flush_mul_t13_done", 32'(done_o), 32'd1);
    chk("flush_mul_result", result_o, 32'd12);
    chk("flush_mul_waddr", 32'(reg_waddr_o), 32'd22);

    // Reset in the middle of a divide, start_i held high throughout reset
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'b100; op1_i = 32'd50; op2_i = 32'd5; reg_waddr_i = 5'd23;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1; start_i = 1'b1;
    @(negedge clk);
    chk("midrst_busy",   32'(busy_o), 32'd0);
    chk("midrst_done",   32'(done_o), 32'd0);
    chk("midrst_we",     32'(reg_we_o), 32'd0);
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_waddr",  32'(reg_waddr_o), 32'd0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    begin
      bit saw_done = 1'b0;
      bit saw_busy = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (done_o) saw_done = 1'b1;
        if (busy_o) saw_busy = 1'b1;
      end
      chk("midrst_no_done", 32'(saw_done), 32'd0);
      chk("midrst_no_busy", 32'(saw_busy), 32'd0);
    end
    run_vec('{"MUL_after_rst", 3'b000, 32'd3, 32'd4, 5'd24, 32'd12, 2});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
